// File: rtl/regfile_writeback_arbiter_pkg.sv
// Shared definitions for the register-file writeback path.
//   - Default datapath widths (data, register address).
//   - ZERO_REGISTER: the hardwired-zero register; writes to it are dropped.
//   - Requester index constants for the three writeback sources.
//   - ptr_width(): width of a round-robin pointer for n requesters.
package regfile_writeback_arbiter_pkg;

  localparam int DATA_WIDTH_DEFAULT   = 32;
  localparam int ADDRESS_SIZE_DEFAULT = 5;
  localparam int ZERO_REGISTER        = 0;

  // Writeback source indices (position in req_valid / req_ready).
  localparam int WB_ALU    = 0;
  localparam int WB_LOAD   = 1;
  localparam int WB_MULDIV = 2;

  // A single requester still needs a 1-bit pointer so the port is legal.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_writeback_arbiter_round_robin_arbiter.sv
// Purely combinational round-robin arbiter, reusable for any shared port.
// Ports:
//   request  in  N       request vector
//   pointer  in  PTR_W   index of the last granted requester
//   grant    out N       one-hot grant (all-zero when no request)
// The search starts at pointer+1 and wraps modulo N, so the last winner has
// the lowest priority on the next round.
module round_robin_arbiter
  import regfile_writeback_arbiter_pkg::*;
#(
  parameter int N     = 3,
  parameter int PTR_W = ptr_width(N)
) (
  input  logic [N-1:0]     request,
  input  logic [PTR_W-1:0] pointer,
  output logic [N-1:0]     grant
);

  always_comb begin
    logic found;
    int   idx;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(pointer) + k) % N;
      if (!found && request[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_writeback_arbiter.sv
// Shares the single register-file write port between NUM_REQUESTERS
// writeback sources with round-robin arbitration and one registered stage.
// Ports:
//   system_clock, system_reset_n   clock, asynchronous active-low reset
//   flush                          synchronous pipeline flush
//   req_valid/req_address/req_data per-requester write requests (flattened)
//   req_ready                      one-hot grant
//   write_enable/address/data      register-file write port
//   pending_valid/address/data     in-flight write for decode forwarding
//   conflict_count                 saturating count of contended cycles
// Handshake: a requester transfers in any cycle where req_valid[i] and
// req_ready[i] are both high; ready is combinational on valid, so requesters
// hold valid/address/data stable until ready and never gate valid on ready.
module regfile_writeback_arbiter
  import regfile_writeback_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS = 3,
  parameter int DATA_WIDTH     = DATA_WIDTH_DEFAULT,
  parameter int ADDRESS_SIZE   = ADDRESS_SIZE_DEFAULT,
  parameter int COUNTER_WIDTH  = 16
) (
  input  logic                                   system_clock,
  input  logic                                   system_reset_n,
  input  logic                                   flush,
  input  logic [NUM_REQUESTERS-1:0]              req_valid,
  input  logic [NUM_REQUESTERS*ADDRESS_SIZE-1:0] req_address,
  input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQUESTERS-1:0]              req_ready,
  output logic                                   write_enable,
  output logic [ADDRESS_SIZE-1:0]                write_address,
  output logic [DATA_WIDTH-1:0]                  write_data,
  output logic                                   pending_valid,
  output logic [ADDRESS_SIZE-1:0]                pending_address,
  output logic [DATA_WIDTH-1:0]                  pending_data,
  output logic [COUNTER_WIDTH-1:0]               conflict_count
);

  localparam int                 PTR_W     = ptr_width(NUM_REQUESTERS);
  // Pointing at the last requester gives requester 0 first priority.
  localparam logic [PTR_W-1:0]   PTR_RESET = PTR_W'(NUM_REQUESTERS - 1);
  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = '1;

  logic [PTR_W-1:0]          pointer;
  logic [NUM_REQUESTERS-1:0] arb_grant;
  logic [PTR_W-1:0]          grant_index;
  logic [ADDRESS_SIZE-1:0]   sel_address;
  logic [DATA_WIDTH-1:0]     sel_data;
  logic                      transfer;
  logic                      multi_valid;

  round_robin_arbiter #(
    .N     (NUM_REQUESTERS),
    .PTR_W (PTR_W)
  ) u_arbiter (
    .request (req_valid),
    .pointer (pointer),
    .grant   (arb_grant)
  );

  // No grant during flush or while reset is held.
  assign req_ready = (system_reset_n && !flush) ? arb_grant : '0;
  assign transfer  = |req_ready;

  // Mux the winning requester's payload and encode its index.
  always_comb begin
    grant_index = '0;
    sel_address = '0;
    sel_data    = '0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      if (req_ready[i]) begin
        grant_index = PTR_W'(i);
        sel_address = req_address[i*ADDRESS_SIZE +: ADDRESS_SIZE];
        sel_data    = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    int valid_count;
    valid_count = 0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      valid_count = valid_count + int'(req_valid[i]);
    end
    multi_valid = (valid_count > 1);
  end

  always_ff @(posedge system_clock or negedge system_reset_n) begin
    if (!system_reset_n) begin
      pointer <= PTR_RESET;
    end else if (flush) begin
      pointer <= PTR_RESET;
    end else if (transfer) begin
      pointer <= grant_index;
    end
  end

  // Output stage drains every cycle: the register file always accepts.
  // Address/data only change on a transfer so forwarding sees stable values.
  always_ff @(posedge system_clock or negedge system_reset_n) begin
    if (!system_reset_n) begin
      write_enable  <= 1'b0;
      write_address <= '0;
      write_data    <= '0;
    end else if (flush) begin
      write_enable  <= 1'b0;
    end else if (transfer) begin
      // Register 0 is accepted but never written nor forwarded.
      write_enable  <= (sel_address != ADDRESS_SIZE'(ZERO_REGISTER));
      write_address <= sel_address;
      write_data    <= sel_data;
    end else begin
      write_enable  <= 1'b0;
    end
  end

  always_ff @(posedge system_clock or negedge system_reset_n) begin
    if (!system_reset_n) begin
      conflict_count <= '0;
    end else if (multi_valid && !flush && (conflict_count != CNT_MAX)) begin
      conflict_count <= conflict_count + 1'b1;
    end
  end

  assign pending_valid   = write_enable;
  assign pending_address = write_address;
  assign pending_data    = write_data;

endmodule
